// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline MEM stage: access-size codes, writeback-select
// encodings and the memory-handshake FSM state type.
package pipeline_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StResp = 2'b10
  } mem_state_e;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } access_size_e;

  // Anything outside the byte/half encodings is handled as a full word.
  function automatic access_size_e f3_size(input logic [2:0] f3);
    access_size_e size;
    case (f3)
      F3_LB, F3_LBU: size = SizeByte;
      F3_LH, F3_LHU: size = SizeHalf;
      default:       size = SizeWord;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the MEM stage: store byte enables and lane replication,
// load byte/half extraction with sign or zero extension, and alignment checking.
module load_store_align
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      load_lane,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic            aligned,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  access_size_e size;
  logic [7:0]   rbyte;
  logic [15:0]  rhalf;

  assign size  = f3_size(funct3);
  assign rbyte = rdata[{load_lane, 3'b000} +: 8];
  assign rhalf = load_lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    wdata   = store_data;
    case (size)
      SizeByte: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SizeHalf: begin
        aligned = ~addr_lo[0];
        be      = 4'b0011 << addr_lo;
        wdata   = {2{store_data[15:0]}};
      end
      default: begin
        aligned = (addr_lo == 2'b00);
      end
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      F3_LBU:  load_data = {24'h000000, rbyte};
      F3_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      F3_LHU:  load_data = {16'h0000, rhalf};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/pipeline_memory_access.sv
// MEM stage: drives the data-memory req/gnt/rvalid handshake, stalls upstream while an
// access is outstanding, and registers the MEM/WB values consumed by writeback.
module pipeline_memory_access
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic [XLEN-1:0]       pcsrc_i,
  input  logic [XLEN-1:0]       offset_i,
  input  logic [1:0]            dmem_to_reg_i,
  input  logic                  reg_write_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [XLEN-1:0]       dmem_addr_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  misalign_o,
  output logic                  wb_valid_o,
  output logic                  wb_reg_write_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [1:0]            wb_dmem_to_reg_o,
  output logic [XLEN-1:0]       wb_mem_data_read_o,
  output logic [XLEN-1:0]       wb_alu_result_o,
  output logic [XLEN-1:0]       wb_pcsrc_o,
  output logic [XLEN-1:0]       wb_offset_o
);

  mem_state_e state_q, state_d;
  logic       discard_q, discard_d;
  logic [1:0] lane_q, lane_d;

  logic            is_access, is_store, is_load;
  logic            aligned, misaligned, mem_op;
  logic            req, done, stall, bus_req;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, load_data;

  logic                  misalign_q;
  logic                  wb_valid_q, wb_reg_write_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [1:0]            wb_dmem_to_reg_q;
  logic [XLEN-1:0]       wb_mem_data_q, wb_alu_result_q, wb_pcsrc_q, wb_offset_q;

  load_store_align #(
    .XLEN (XLEN)
  ) u_align (
    .funct3     (funct3_i),
    .addr_lo    (alu_result_i[1:0]),
    .load_lane  (lane_q),
    .store_data (store_data_i),
    .rdata      (dmem_rdata_i),
    .aligned    (aligned),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  assign is_access  = valid_i & (mem_read_i | mem_write_i);
  assign is_store   = mem_write_i;
  assign is_load    = mem_read_i & ~mem_write_i;
  assign misaligned = is_access & ~aligned;
  assign mem_op     = is_access & aligned;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    lane_d    = lane_q;
    req       = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        req = mem_op & ~flush_i;
        if (req) begin
          lane_d    = alu_result_i[1:0];
          discard_d = 1'b0;
          if (dmem_gnt_i) begin
            if (is_store) done = 1'b1;
            else          state_d = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          req = 1'b1;
          if (dmem_gnt_i) begin
            if (is_store) begin
              done    = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StResp;
            end
          end
        end
      end
      StResp: begin
        // A flushed load still owns the bus until its response; remember to drop it.
        if (flush_i) discard_d = 1'b1;
        if (dmem_rvalid_i) begin
          done      = is_load & ~discard_q;
          discard_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
      lane_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      lane_q    <= lane_d;
    end
  end

  // Reset gates the combinational outputs so everything reads zero while reset_i is low.
  assign bus_req      = reset_i & req;
  assign stall        = reset_i & mem_op & ~done & ~flush_i;
  assign stall_o      = stall;
  assign dmem_req_o   = bus_req;
  assign dmem_we_o    = bus_req & is_store;
  assign dmem_addr_o  = bus_req ? {alu_result_i[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata_o = (bus_req & is_store) ? wdata : '0;
  assign dmem_be_o    = (bus_req & is_store) ? be : 4'b0000;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      misalign_q       <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_rd_q          <= '0;
      wb_dmem_to_reg_q <= 2'b00;
      wb_mem_data_q    <= '0;
      wb_alu_result_q  <= '0;
      wb_pcsrc_q       <= '0;
      wb_offset_q      <= '0;
    end else begin
      misalign_q <= misaligned & ~flush_i;
      if (stall || flush_i) begin
        wb_valid_q     <= 1'b0;
        wb_reg_write_q <= 1'b0;
      end else begin
        wb_valid_q       <= valid_i & ~misaligned;
        wb_reg_write_q   <= reg_write_i & valid_i & ~misaligned;
        wb_rd_q          <= rd_i;
        wb_dmem_to_reg_q <= dmem_to_reg_i;
        wb_mem_data_q    <= load_data;
        wb_alu_result_q  <= alu_result_i;
        wb_pcsrc_q       <= pcsrc_i;
        wb_offset_q      <= offset_i;
      end
    end
  end

  assign misalign_o         = misalign_q;
  assign wb_valid_o         = wb_valid_q;
  assign wb_reg_write_o     = wb_reg_write_q;
  assign wb_rd_o            = wb_rd_q;
  assign wb_dmem_to_reg_o   = wb_dmem_to_reg_q;
  assign wb_mem_data_read_o = wb_mem_data_q;
  assign wb_alu_result_o    = wb_alu_result_q;
  assign wb_pcsrc_o         = wb_pcsrc_q;
  assign wb_offset_o        = wb_offset_q;

endmodule

// File: tb/tb_pipeline_memory_access.sv
// Directed bench for the MEM stage: ALU pass-through, stores, loads with wait states,
// misalignment, flush during a response and reset during an access.
module tb_pipeline_memory_access;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i, mem_read_i, mem_write_i, reg_write_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, store_data_i, pcsrc_i, offset_i;
  logic [1:0]  dmem_to_reg_i;
  logic [4:0]  rd_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        misalign_o, wb_valid_o, wb_reg_write_o;
  logic [4:0]  wb_rd_o;
  logic [1:0]  wb_dmem_to_reg_o;
  logic [31:0] wb_mem_data_read_o, wb_alu_result_o, wb_pcsrc_o, wb_offset_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  pipeline_memory_access #(
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .valid_i            (valid_i),
    .mem_read_i         (mem_read_i),
    .mem_write_i        (mem_write_i),
    .funct3_i           (funct3_i),
    .alu_result_i       (alu_result_i),
    .store_data_i       (store_data_i),
    .pcsrc_i            (pcsrc_i),
    .offset_i           (offset_i),
    .dmem_to_reg_i      (dmem_to_reg_i),
    .reg_write_i        (reg_write_i),
    .rd_i               (rd_i),
    .flush_i            (flush_i),
    .stall_o            (stall_o),
    .dmem_req_o         (dmem_req_o),
    .dmem_we_o          (dmem_we_o),
    .dmem_addr_o        (dmem_addr_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_be_o          (dmem_be_o),
    .dmem_gnt_i         (dmem_gnt_i),
    .dmem_rvalid_i      (dmem_rvalid_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .misalign_o         (misalign_o),
    .wb_valid_o         (wb_valid_o),
    .wb_reg_write_o     (wb_reg_write_o),
    .wb_rd_o            (wb_rd_o),
    .wb_dmem_to_reg_o   (wb_dmem_to_reg_o),
    .wb_mem_data_read_o (wb_mem_data_read_o),
    .wb_alu_result_o    (wb_alu_result_o),
    .wb_pcsrc_o         (wb_pcsrc_o),
    .wb_offset_o        (wb_offset_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    valid_i       = 1'b0;
    mem_read_i    = 1'b0;
    mem_write_i   = 1'b0;
    funct3_i      = 3'b000;
    alu_result_i  = 32'h0;
    store_data_i  = 32'h0;
    pcsrc_i       = 32'h0;
    offset_i      = 32'h0;
    dmem_to_reg_i = 2'b00;
    reg_write_i   = 1'b0;
    rd_i          = 5'd0;
    flush_i       = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  task automatic set_load(input logic [2:0] f3, input logic [31:0] addr);
    valid_i      = 1'b1;
    mem_read_i   = 1'b1;
    funct3_i     = f3;
    alu_result_i = addr;
    reg_write_i  = 1'b1;
    rd_i         = 5'd9;
  endtask

  // Load granted in its first cycle, data returned one cycle later.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk_i);
    set_load(f3, addr);
    dmem_gnt_i = 1'b1;
    #1;
    check_eq({tag, "_req"}, dmem_req_o, 1);
    check_eq({tag, "_stall_req"}, stall_o, 1);
    @(negedge clk_i);
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    #1;
    check_eq({tag, "_stall_resp"}, stall_o, 0);
    @(posedge clk_i);
    #1;
    check_eq({tag, "_wb_valid"}, wb_valid_o, 1);
    check_eq({tag, "_data"}, wb_mem_data_read_o, exp);
    @(negedge clk_i);
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_i = 1'b0;
    // A live load held at the inputs during reset must not reach the bus.
    set_load(3'b010, 32'h10);
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_req", dmem_req_o, 0);
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_wb_valid", wb_valid_o, 0);
    check_eq("rst_misalign", misalign_o, 0);
    check_eq("rst_addr", dmem_addr_o, 0);
    @(negedge clk_i);
    clear_inputs();
    reset_i = 1'b1;

    // ALU op passes straight through in one cycle.
    @(negedge clk_i);
    valid_i = 1'b1; alu_result_i = 32'h1234; dmem_to_reg_i = 2'b01; rd_i = 5'd5;
    reg_write_i = 1'b1; pcsrc_i = 32'h44; offset_i = 32'h8;
    #1;
    check_eq("alu_stall", stall_o, 0);
    check_eq("alu_req", dmem_req_o, 0);
    @(posedge clk_i);
    #1;
    check_eq("alu_wb_valid", wb_valid_o, 1);
    check_eq("alu_wb_result", wb_alu_result_o, 32'h1234);
    check_eq("alu_wb_rd", wb_rd_o, 5);
    check_eq("alu_wb_regwr", wb_reg_write_o, 1);
    check_eq("alu_wb_sel", wb_dmem_to_reg_o, 2'b01);
    check_eq("alu_wb_pc", wb_pcsrc_o, 32'h44);
    check_eq("alu_wb_off", wb_offset_o, 32'h8);
    @(negedge clk_i);
    clear_inputs();

    // SB to byte lane 3, granted immediately.
    @(negedge clk_i);
    valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b000; alu_result_i = 32'h1003;
    store_data_i = 32'h0000_00AB; dmem_gnt_i = 1'b1;
    #1;
    check_eq("sb_req", dmem_req_o, 1);
    check_eq("sb_we", dmem_we_o, 1);
    check_eq("sb_be", dmem_be_o, 4'b1000);
    check_eq("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    check_eq("sb_addr", dmem_addr_o, 32'h1000);
    check_eq("sb_stall", stall_o, 0);
    @(posedge clk_i);
    #1;
    check_eq("sb_wb_valid", wb_valid_o, 1);
    @(negedge clk_i);
    clear_inputs();

    // SH to upper half.
    @(negedge clk_i);
    valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b001; alu_result_i = 32'h1002;
    store_data_i = 32'h1234_BEEF; dmem_gnt_i = 1'b1;
    #1;
    check_eq("sh_be", dmem_be_o, 4'b1100);
    check_eq("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    @(negedge clk_i);
    clear_inputs();

    // LH with two wait cycles before gnt, rvalid one cycle after gnt.
    @(negedge clk_i);
    set_load(3'b001, 32'h2002);
    #1;
    check_eq("lh_stall_c0", stall_o, 1);
    check_eq("lh_req_c0", dmem_req_o, 1);
    check_eq("lh_addr_c0", dmem_addr_o, 32'h2000);
    @(posedge clk_i);
    #1;
    check_eq("lh_wb_bubble", wb_valid_o, 0);
    @(negedge clk_i);
    #1;
    check_eq("lh_stall_c1", stall_o, 1);
    check_eq("lh_req_c1", dmem_req_o, 1);
    @(negedge clk_i);
    dmem_gnt_i = 1'b1;
    #1;
    check_eq("lh_stall_c2", stall_o, 1);
    check_eq("lh_req_c2", dmem_req_o, 1);
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_0000;
    #1;
    check_eq("lh_stall_c3", stall_o, 0);
    check_eq("lh_req_c3", dmem_req_o, 0);
    @(posedge clk_i);
    #1;
    check_eq("lh_wb_valid", wb_valid_o, 1);
    check_eq("lh_data", wb_mem_data_read_o, 32'hFFFF_8001);
    check_eq("lh_rd", wb_rd_o, 9);
    @(negedge clk_i);
    clear_inputs();

    do_load("lbu", 3'b100, 32'h2001, 32'h0000_F000, 32'h0000_00F0);
    do_load("lb",  3'b000, 32'h2001, 32'h0000_F000, 32'hFFFF_FFF0);
    do_load("lhu", 3'b101, 32'h2000, 32'h1234_9ABC, 32'h0000_9ABC);
    do_load("lw",  3'b010, 32'h2004, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Misaligned LW: no request, one-cycle misalign pulse, bubble.
    @(negedge clk_i);
    set_load(3'b010, 32'h3002);
    #1;
    check_eq("mis_req", dmem_req_o, 0);
    check_eq("mis_stall", stall_o, 0);
    @(posedge clk_i);
    #1;
    check_eq("mis_pulse", misalign_o, 1);
    check_eq("mis_wb_regwr", wb_reg_write_o, 0);
    check_eq("mis_wb_valid", wb_valid_o, 0);
    @(negedge clk_i);
    clear_inputs();
    @(posedge clk_i);
    #1;
    check_eq("mis_pulse_end", misalign_o, 0);

    // Flush while waiting for the response: data discarded, FSM back to idle.
    @(negedge clk_i);
    set_load(3'b010, 32'h4000);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; flush_i = 1'b1;
    #1;
    check_eq("fl_stall", stall_o, 0);
    @(posedge clk_i);
    #1;
    check_eq("fl_wb_c1", wb_valid_o, 0);
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
    @(posedge clk_i);
    #1;
    check_eq("fl_wb_rvalid", wb_valid_o, 0);
    @(negedge clk_i);
    clear_inputs();
    set_load(3'b010, 32'h5000);
    #1;
    check_eq("fl_idle_req", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
    @(posedge clk_i);
    #1;
    check_eq("fl_next_data", wb_mem_data_read_o, 32'h0BAD_F00D);
    check_eq("fl_next_alu", wb_alu_result_o, 32'h5000);
    @(negedge clk_i);
    clear_inputs();

    // Reset asserted while in RESP; a late rvalid afterwards is ignored.
    @(negedge clk_i);
    set_load(3'b010, 32'h6000);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    #1;
    check_eq("rr_stall_resp", stall_o, 1);
    reset_i = 1'b0;
    #1;
    check_eq("rr_stall", stall_o, 0);
    check_eq("rr_req", dmem_req_o, 0);
    check_eq("rr_wb_alu", wb_alu_result_o, 0);
    check_eq("rr_wb_data", wb_mem_data_read_o, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    clear_inputs();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    @(posedge clk_i);
    #1;
    check_eq("rr_late_rvalid", wb_valid_o, 0);
    @(negedge clk_i);
    clear_inputs();
    set_load(3'b010, 32'h6000);
    #1;
    check_eq("rr_idle_req", dmem_req_o, 1);
    check_eq("rr_idle_stall", stall_o, 1);
    @(negedge clk_i);
    clear_inputs();
    flush_i = 1'b1;
    @(negedge clk_i);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
